edge_event_arbiter: RTL and testbench
=====================================

Name: edge_event_arbiter

Overview:
Collects rising/falling edge pulses from NUM_CH upstream edge_detec instances (RE_detected/FE_detected per channel) and holds each as a pending event. Serializes the pending events onto one valid/ready event stream, tagging each event with its channel number and edge type. Channels are served round-robin; within a channel, rising is served before falling. Events that would be lost are flagged per channel.

Parameters:
NUM_CH, 4, number of edge channels (>=2)
CH_W, $clog2(NUM_CH), derived localparam; width of the channel index

Ports:
clk  input  1  single clock, all logic on posedge
reset  input  1  synchronous, active-high
re_pulse  input  NUM_CH  per-channel single-cycle rising-edge pulse (from RE_detected)
fe_pulse  input  NUM_CH  per-channel single-cycle falling-edge pulse (from FE_detected)
chan_en  input  NUM_CH  per-channel enable
evt_valid  output  1  event present on evt_chan/evt_rise
evt_ready  input  1  consumer accepts the event when evt_valid && evt_ready at posedge
evt_chan  output  CH_W  channel index of the presented event
evt_rise  output  1  1 = rising edge, 0 = falling edge
ovf  output  NUM_CH  sticky per-channel overflow flags
ovf_clear  input  1  clears all ovf bits

Behaviour:
- Reset (sampled at posedge): pend_re, pend_fe, ovf, evt_valid, evt_chan, evt_rise all 0; round-robin pointer = 0. A reset mid-stream drops the presented event and all pending events.
- Request per slot: req_re[i] = (pend_re[i] | re_pulse[i]) & chan_en[i]; req_fe is defined the same way from pend_fe/fe_pulse.
- Load condition: load = !evt_valid | evt_ready. On load, if any request exists, the winner is registered into evt_chan/evt_rise and evt_valid=1. If no request exists, evt_valid=0.
- Outputs are registered. evt_chan/evt_rise are stable while evt_valid && !evt_ready.
- Latency: a pulse sampled at posedge t with an empty output appears as evt_valid=1 after posedge t (visible in cycle t+1).
- Throughput: one event per cycle when evt_ready is held high.
- Arbitration:
  - Scan channels starting at ptr, ascending with wrap modulo NUM_CH. The first channel with req_re|req_fe wins.
  - That channel's rise is granted if req_re is set, otherwise its fall.
  - On a grant, ptr <= winner+1 (wrapping from NUM_CH-1 to 0). ptr is unchanged when there is no grant.
- Pending update per slot (shown for re; fe is identical):
  - Granted this cycle: pend_re <= pend_re & re_pulse. The pending event is consumed and a simultaneous new pulse re-arms the slot. A bypass grant of a fresh pulse leaves pend 0.
  - Not granted: pend_re <= pend_re | re_pulse.
  - A pulse arriving while pend_re=1 and the slot is not granted is dropped, and ovf[i] <= 1.
- chan_en[i]=0: pulses on channel i are ignored, pend_re[i]/pend_fe[i] are cleared next cycle, and no ovf is set. An event already presented on evt_* is not withdrawn.
- Rise and fall pulses in the same cycle on one channel: both are pending. Rise is served first; fall is served at the channel's next round-robin turn.
- ovf_clear clears all ovf bits. A new overflow in the same cycle wins: that bit stays set.
- Boundaries:
  - NUM_CH not a power of two: ptr wraps explicitly at NUM_CH-1. evt_chan never exceeds NUM_CH-1.
  - All channels requesting with evt_ready=1: the grant sequence rotates fairly.

Decomposition:
- Package edge_evt_pkg:
  - typedef edge_evt_t {logic [CH_W-1:0] chan; logic rise;}
  - constants EDGE_RISE=1'b1, EDGE_FALL=1'b0.
- Sub-module rr_arbiter: parameter N; inputs req[N] and ptr; outputs grant_valid and grant_idx. Purely combinational priority rotation.
- The top level holds the pending registers, the ovf logic, ptr and the output register.

Test Plan:
- Reset with re_pulse=4'b1111 driven -> after release evt_valid=0, ovf=0. The first pulse on ch2 then gives evt_valid=1, evt_chan=2, evt_rise=1 one cycle later.
- evt_ready=1; re_pulse=4'b1111 for one cycle, ptr=0 -> events chan 0,1,2,3 (rise) on four consecutive cycles, then evt_valid=0.
- ch1 re_pulse and fe_pulse together, evt_ready=1 -> (1,rise), then (1,fall) on its next turn. No ovf.
- evt_ready=0 with ch0 event presented; re_pulse[3] twice, 3 cycles apart -> ovf[3]=1 and a single (3,rise) is delivered after ready rises. ovf_clear then gives ovf=0.
- chan_en=4'b1011; re_pulse=4'b0100 -> no event and no ovf. Pulses on ch3 are delivered normally.
- Reset asserted while evt_valid=1 and pend=4'b0110 -> next cycle evt_valid=0 and pending empty. No stale events after release.

Source files
------------

// File: rtl/edge_evt_pkg.sv
// Shared types and constants for the edge event arbiter.
// edge_evt_t is sized for the default channel count.
package edge_evt_pkg;

  localparam int unsigned NumChDefault = 4;
  localparam int unsigned CH_W         = $clog2(NumChDefault);

  localparam logic EDGE_RISE = 1'b1;
  localparam logic EDGE_FALL = 1'b0;

  typedef struct packed {
    logic [CH_W-1:0] chan;
    logic            rise;
  } edge_evt_t;

endpackage

// File: rtl/edge_evt_if.sv
// Valid/ready event stream carrying a channel index and an edge type.
interface edge_evt_if #(
  parameter int unsigned NUM_CH = 4
) ();
  localparam int unsigned CH_W = $clog2(NUM_CH);

  logic            evt_valid;
  logic            evt_ready;
  logic [CH_W-1:0] evt_chan;
  logic            evt_rise;

  modport master (output evt_valid, output evt_chan, output evt_rise, input evt_ready);
  modport slave  (input evt_valid, input evt_chan, input evt_rise, output evt_ready);
endinterface

// File: rtl/edge_event_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after i_ptr, with wrap.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         i_req,
  input  logic [$clog2(N)-1:0] i_ptr,
  output logic                 o_grant_valid,
  output logic [$clog2(N)-1:0] o_grant_idx
);
  localparam int unsigned W = $clog2(N);

  int unsigned w_idx;

  always_comb begin
    o_grant_valid = 1'b0;
    o_grant_idx   = '0;
    w_idx         = 0;
    for (int unsigned k = 0; k < N; k++) begin
      // Explicit wrap keeps non-power-of-two channel counts in range.
      w_idx = {{(32-W){1'b0}}, i_ptr} + k;
      if (w_idx >= N) w_idx = w_idx - N;
      if (!o_grant_valid && i_req[W'(w_idx)]) begin
        o_grant_valid = 1'b1;
        o_grant_idx   = W'(w_idx);
      end
    end
  end

endmodule

// File: rtl/edge_event_arbiter.sv
// Holds per-channel rising/falling edge events and serialises them round-robin
// onto a registered valid/ready stream, flagging events lost to a busy slot.
module edge_event_arbiter
  import edge_evt_pkg::*;
#(
  parameter int unsigned NUM_CH = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [NUM_CH-1:0] i_re_pulse,
  input  logic [NUM_CH-1:0] i_fe_pulse,
  input  logic [NUM_CH-1:0] i_chan_en,
  input  logic              i_ovf_clear,
  output logic [NUM_CH-1:0] o_ovf,
  edge_evt_if.master        evt_if
);
  localparam int unsigned     CH_W   = $clog2(NUM_CH);
  localparam logic [CH_W-1:0] LastCh = CH_W'(NUM_CH - 1);

  logic [NUM_CH-1:0] r_pend_re, r_pend_fe, r_ovf;
  logic [CH_W-1:0]   r_ptr;
  logic              r_evt_valid;
  logic [CH_W-1:0]   r_evt_chan;
  logic              r_evt_rise;

  logic [NUM_CH-1:0] w_req_re, w_req_fe, w_req_any;
  logic [NUM_CH-1:0] w_gnt_re, w_gnt_fe;
  logic [NUM_CH-1:0] w_pend_re_d, w_pend_fe_d, w_ovf_set;
  logic              w_load, w_grant, w_gnt_valid, w_gnt_rise;
  logic [CH_W-1:0]   w_gnt_idx;

  assign w_req_re  = (r_pend_re | i_re_pulse) & i_chan_en;
  assign w_req_fe  = (r_pend_fe | i_fe_pulse) & i_chan_en;
  assign w_req_any = w_req_re | w_req_fe;
  assign w_load    = !r_evt_valid || evt_if.evt_ready;
  assign w_grant   = w_load && w_gnt_valid;

  rr_arbiter #(
    .N (NUM_CH)
  ) u_rr_arbiter (
    .i_req         (w_req_any),
    .i_ptr         (r_ptr),
    .o_grant_valid (w_gnt_valid),
    .o_grant_idx   (w_gnt_idx)
  );

  always_comb begin
    w_gnt_rise  = w_req_re[w_gnt_idx] ? EDGE_RISE : EDGE_FALL;
    w_gnt_re    = '0;
    w_gnt_fe    = '0;
    w_pend_re_d = '0;
    w_pend_fe_d = '0;
    w_ovf_set   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_gnt_re[i] = w_grant && (w_gnt_idx == CH_W'(i)) && (w_gnt_rise == EDGE_RISE);
      w_gnt_fe[i] = w_grant && (w_gnt_idx == CH_W'(i)) && (w_gnt_rise == EDGE_FALL);
      // A granted slot consumes its pending event; a coincident pulse re-arms it.
      if (i_chan_en[i]) begin
        w_pend_re_d[i] = w_gnt_re[i] ? (r_pend_re[i] & i_re_pulse[i])
                                     : (r_pend_re[i] | i_re_pulse[i]);
        w_pend_fe_d[i] = w_gnt_fe[i] ? (r_pend_fe[i] & i_fe_pulse[i])
                                     : (r_pend_fe[i] | i_fe_pulse[i]);
        w_ovf_set[i]   = (i_re_pulse[i] && r_pend_re[i] && !w_gnt_re[i]) ||
                         (i_fe_pulse[i] && r_pend_fe[i] && !w_gnt_fe[i]);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pend_re   <= '0;
      r_pend_fe   <= '0;
      r_ovf       <= '0;
      r_ptr       <= '0;
      r_evt_valid <= 1'b0;
      r_evt_chan  <= '0;
      r_evt_rise  <= 1'b0;
    end else begin
      r_pend_re <= w_pend_re_d;
      r_pend_fe <= w_pend_fe_d;
      r_ovf     <= (r_ovf & {NUM_CH{!i_ovf_clear}}) | w_ovf_set;
      if (w_grant) r_ptr <= (w_gnt_idx == LastCh) ? '0 : w_gnt_idx + 1'b1;
      if (w_load) begin
        r_evt_valid <= w_gnt_valid;
        if (w_gnt_valid) begin
          r_evt_chan <= w_gnt_idx;
          r_evt_rise <= w_gnt_rise;
        end
      end
    end
  end

  assign o_ovf            = r_ovf;
  assign evt_if.evt_valid = r_evt_valid;
  assign evt_if.evt_chan  = r_evt_chan;
  assign evt_if.evt_rise  = r_evt_rise;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Self-checking bench: directed scenarios plus randomised traffic against a
// behavioural model of the pending/round-robin/overflow rules.
module tb_edge_event_arbiter;
  import edge_evt_pkg::*;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] re_pulse, fe_pulse, chan_en, ovf;
  logic         ovf_clear;

  edge_evt_if #(.NUM_CH(N)) evt_if ();

  edge_event_arbiter #(
    .NUM_CH (N)
  ) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_re_pulse  (re_pulse),
    .i_fe_pulse  (fe_pulse),
    .i_chan_en   (chan_en),
    .i_ovf_clear (ovf_clear),
    .o_ovf       (ovf),
    .evt_if      (evt_if.master)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit        m_valid;
  edge_evt_t m_evt;
  bit [N-1:0] m_pend_re, m_pend_fe, m_ovf;
  int        m_ptr;

  task automatic model_step();
    bit load, found;
    int win, c;
    bit [N-1:0] req_re, req_fe, g_re, g_fe, set;
    if (reset) begin
      m_valid = 0; m_evt = '0; m_pend_re = '0; m_pend_fe = '0; m_ovf = '0; m_ptr = 0;
      return;
    end
    load   = !m_valid || evt_if.evt_ready;
    req_re = (m_pend_re | re_pulse) & chan_en;
    req_fe = (m_pend_fe | fe_pulse) & chan_en;
    found  = 0;
    win    = 0;
    for (int k = 0; k < N; k++) begin
      c = (m_ptr + k) % N;
      if (!found && (req_re[c] || req_fe[c])) begin
        found = 1;
        win   = c;
      end
    end
    g_re = '0;
    g_fe = '0;
    if (load) begin
      m_valid = found;
      if (found) begin
        m_evt.chan = 2'(win);
        m_evt.rise = req_re[win];
        m_ptr      = (win + 1) % N;
        if (req_re[win]) g_re[win] = 1;
        else g_fe[win] = 1;
      end
    end
    set = '0;
    for (int i = 0; i < N; i++) begin
      if (!chan_en[i]) begin
        m_pend_re[i] = 0;
        m_pend_fe[i] = 0;
      end else begin
        if (re_pulse[i] && m_pend_re[i] && !g_re[i]) set[i] = 1;
        if (fe_pulse[i] && m_pend_fe[i] && !g_fe[i]) set[i] = 1;
        m_pend_re[i] = g_re[i] ? (m_pend_re[i] & re_pulse[i]) : (m_pend_re[i] | re_pulse[i]);
        m_pend_fe[i] = g_fe[i] ? (m_pend_fe[i] & fe_pulse[i]) : (m_pend_fe[i] | fe_pulse[i]);
      end
    end
    if (ovf_clear) m_ovf = '0;
    m_ovf |= set;
  endtask

  // Advance one clock; outputs are observed 1 time unit after the edge.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    re_pulse  = '0;
    fe_pulse  = '0;
    ovf_clear = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    chan_en  = '1;
    evt_if.evt_ready = 1'b1;
    re_pulse = 4'b1111;
    fe_pulse = '0;
    ovf_clear = 1'b0;
    tick();
    tick();
    reset    = 1'b0;
    re_pulse = '0;
    n_checks++;
    if (evt_if.evt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid: got %b expected 0", evt_if.evt_valid);
    end
    n_checks++;
    if (ovf !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ovf: got %b expected 0000", ovf);
    end
    tick();
    n_checks++;
    if (evt_if.evt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_stale: got %b expected 0", evt_if.evt_valid);
    end
    re_pulse = 4'b0100;
    tick();
    re_pulse = '0;
    n_checks++;
    if ({evt_if.evt_valid, evt_if.evt_chan, evt_if.evt_rise} !== 4'b1_10_1) begin
      n_fail++;
      $display("FAIL reset_first_event: got %b expected 1101",
               {evt_if.evt_valid, evt_if.evt_chan, evt_if.evt_rise});
    end
    tick();
    n_checks++;
    if (evt_if.evt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_first_drain: got %b expected 0", evt_if.evt_valid);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp;
    do_reset();
    evt_if.evt_ready = 1'b1;
    re_pulse = 4'b1111;
    tick();
    re_pulse = '0;
    for (int k = 0; k < 4; k++) begin
      exp = {1'b1, 2'(k), 1'b1};
      n_checks++;
      if ({evt_if.evt_valid, evt_if.evt_chan, evt_if.evt_rise} !== exp) begin
        n_fail++;
        $display("FAIL rr_seq[%0d]: got %b expected %b", k,
                 {evt_if.evt_valid, evt_if.evt_chan, evt_if.evt_rise}, exp);
      end
      tick();
    end
    n_checks++;
    if (evt_if.evt_valid !== 1'b0 || ovf !== 4'b0000) begin
      n_fail++;
      $display("FAIL rr_end: got valid=%b ovf=%b expected valid=0 ovf=0000",
               evt_if.evt_valid, ovf);
    end
  endtask

  task automatic test_rise_fall();
    do_reset();
    evt_if.evt_ready = 1'b1;
    re_pulse = 4'b0010;
    fe_pulse = 4'b0010;
    tick();
    idle_inputs();
    n_checks++;
    if ({evt_if.evt_valid, evt_if.evt_chan, evt_if.evt_rise} !== 4'b1_01_1) begin
      n_fail++;
      $display("FAIL rf_rise: got %b expected 1011",
               {evt_if.evt_valid, evt_if.evt_chan, evt_if.evt_rise});
    end
    tick();
    n_checks++;
    if ({evt_if.evt_valid, evt_if.evt_chan, evt_if.evt_rise} !== 4'b1_01_0) begin
      n_fail++;
      $display("FAIL rf_fall: got %b expected 1010",
               {evt_if.evt_valid, evt_if.evt_chan, evt_if.evt_rise});
    end
    tick();
    n_checks++;
    if (evt_if.evt_valid !== 1'b0 || ovf !== 4'b0000) begin
      n_fail++;
      $display("FAIL rf_end: got valid=%b ovf=%b expected valid=0 ovf=0000",
               evt_if.evt_valid, ovf);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    evt_if.evt_ready = 1'b0;
    re_pulse = 4'b0001;
    tick();
    re_pulse = 4'b1000;
    tick();
    re_pulse = '0;
    tick();
    tick();
    re_pulse = 4'b1000;
    tick();
    re_pulse = '0;
    n_checks++;
    if (ovf !== 4'b1000) begin
      n_fail++;
      $display("FAIL ovf_set: got %b expected 1000", ovf);
    end
    n_checks++;
    if ({evt_if.evt_valid, evt_if.evt_chan, evt_if.evt_rise} !== 4'b1_00_1) begin
      n_fail++;
      $display("FAIL ovf_hold: got %b expected 1001",
               {evt_if.evt_valid, evt_if.evt_chan, evt_if.evt_rise});
    end
    evt_if.evt_ready = 1'b1;
    tick();
    n_checks++;
    if ({evt_if.evt_valid, evt_if.evt_chan, evt_if.evt_rise} !== 4'b1_11_1) begin
      n_fail++;
      $display("FAIL ovf_deliver: got %b expected 1111",
               {evt_if.evt_valid, evt_if.evt_chan, evt_if.evt_rise});
    end
    tick();
    n_checks++;
    if (evt_if.evt_valid !== 1'b0 || ovf !== 4'b1000) begin
      n_fail++;
      $display("FAIL ovf_single: got valid=%b ovf=%b expected valid=0 ovf=1000",
               evt_if.evt_valid, ovf);
    end
    ovf_clear = 1'b1;
    tick();
    ovf_clear = 1'b0;
    n_checks++;
    if (ovf !== 4'b0000) begin
      n_fail++;
      $display("FAIL ovf_clear: got %b expected 0000", ovf);
    end
  endtask

  task automatic test_chan_en();
    do_reset();
    evt_if.evt_ready = 1'b1;
    chan_en  = 4'b1011;
    re_pulse = 4'b0100;
    tick();
    re_pulse = '0;
    n_checks++;
    if (evt_if.evt_valid !== 1'b0 || ovf !== 4'b0000) begin
      n_fail++;
      $display("FAIL en_ignore: got valid=%b ovf=%b expected valid=0 ovf=0000",
               evt_if.evt_valid, ovf);
    end
    re_pulse = 4'b1000;
    tick();
    re_pulse = '0;
    n_checks++;
    if ({evt_if.evt_valid, evt_if.evt_chan, evt_if.evt_rise} !== 4'b1_11_1) begin
      n_fail++;
      $display("FAIL en_other: got %b expected 1111",
               {evt_if.evt_valid, evt_if.evt_chan, evt_if.evt_rise});
    end
    chan_en = 4'b1111;
    tick();
    n_checks++;
    if (evt_if.evt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL en_no_pend: got %b expected 0", evt_if.evt_valid);
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    evt_if.evt_ready = 1'b0;
    re_pulse = 4'b0111;
    tick();
    re_pulse = '0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if (evt_if.evt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_valid: got %b expected 0", evt_if.evt_valid);
    end
    evt_if.evt_ready = 1'b1;
    tick();
    tick();
    n_checks++;
    if (evt_if.evt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_stale: got %b expected 0", evt_if.evt_valid);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        re_pulse[i] = ($urandom_range(0, 3) == 0);
        fe_pulse[i] = ($urandom_range(0, 3) == 0);
        chan_en[i]  = ($urandom_range(0, 7) != 0);
      end
      evt_if.evt_ready = ($urandom_range(0, 2) != 0);
      ovf_clear        = ($urandom_range(0, 15) == 0);
      reset            = ($urandom_range(0, 299) == 0);
      tick();
      n_checks++;
      if (evt_if.evt_valid !== m_valid) begin
        n_fail++;
        $display("FAIL rand_valid @%0d: got %b expected %b", cyc, evt_if.evt_valid, m_valid);
      end else if (m_valid) begin
        n_checks++;
        if ({evt_if.evt_chan, evt_if.evt_rise} !== m_evt) begin
          n_fail++;
          $display("FAIL rand_evt @%0d: got chan=%0d rise=%b expected chan=%0d rise=%b", cyc,
                   evt_if.evt_chan, evt_if.evt_rise, m_evt.chan, m_evt.rise);
        end
      end
      n_checks++;
      if (ovf !== m_ovf) begin
        n_fail++;
        $display("FAIL rand_ovf @%0d: got %b expected %b", cyc, ovf, m_ovf);
      end
    end
    reset = 1'b0;
    idle_inputs();
  endtask

  initial begin
    reset            = 1'b1;
    chan_en          = '1;
    evt_if.evt_ready = 1'b0;
    idle_inputs();
    test_reset();
    test_round_robin();
    test_rise_fall();
    test_overflow();
    test_chan_en();
    test_reset_midstream();
    chan_en = '1;
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
